m9k_mem_ctrl: RTL
=================

# m9k_mem_ctrl

Parametrised single-port on-chip RAM controller for M9K block memory, the next generation of the fixed 32-bit M9K wrapper. It adds a valid/ready request interface, per-byte write enables, a registered read response with a valid strobe, out-of-range address detection, and a post-reset hardware clear sequence that zeroes every word. It sits between worker datapath/DMA logic and the local scratch memory.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 1024, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 15, request address width
- BE_W, DATA_W/8, byte-enable width (derived, not overridable)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_be  in  BE_W  byte enables for writes (bit i → bits 8i+7:8i); ignored on reads
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle strobe: read data valid
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualifies rsp_valid: read address was out of range
- init_done  out  1  clear sequence complete
- wr_err  out  1  one-cycle strobe: write dropped, address out of range

## Operation
- States: INIT, RUN.
- rst=1 at an edge: state ← INIT, clear counter ← 0; all outputs ← 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, init_done, wr_err). Memory contents are not reset directly; INIT clears them.
- INIT: each cycle write 0 to M[counter], counter++. req_ready=0; requests ignored. After the cycle writing DEPTH-1, state ← RUN.
- RUN: req_ready=1 every cycle; accept occurs when req_valid & req_ready at an edge.
- Accepted write, req_addr < DEPTH: byte i of M[req_addr] ← req_wdata byte i where req_be[i]=1; other bytes unchanged. req_be=0 is a legal no-op. No response.
- Accepted write, req_addr ≥ DEPTH: memory untouched; wr_err=1 next cycle.
- Accepted read, req_addr < DEPTH: next cycle rsp_valid=1, rsp_rdata=M[req_addr], rsp_err=0.
- Accepted read, req_addr ≥ DEPTH: next cycle rsp_valid=1, rsp_rdata=0, rsp_err=1; no memory access.
- rsp_rdata holds its last value when rsp_valid=0; rsp_err and wr_err are 0 whenever their strobe condition is not met.
- No response backpressure: consumer must take rsp_* on the rsp_valid cycle.
- Single port: one operation per cycle; no simultaneous read/write case exists.
- Memory inferred as M9K (registered read, no asynchronous read path).

## Timing
- Clear length: first edge with rst=0 starts INIT word 0; init_done and req_ready rise exactly DEPTH cycles later (DEPTH=1024 → cycle 1024) and stay 1 until next rst.
- Read latency: 1 cycle (accept at edge N → rsp_valid high during cycle N+1).
- Throughput: 1 request/cycle, reads and writes freely interleaved.
- Read-after-write: read accepted at edge N+1 after write accepted at edge N returns the new data; no forwarding needed beyond RAM ordering.
- Back-to-back reads at edges N, N+1, N+2 → rsp_valid high in N+1..N+3, data in order.
- rst mid-INIT: counter restarts at 0; full DEPTH-cycle clear repeats.
- rst asserted the cycle after a read accept: rsp_valid forced 0 (reset wins); response lost.
- rst mid-RUN: memory re-cleared; all prior contents lost.

## Test plan
- Reset then idle: req_ready=0 and init_done=0 for cycles 0..DEPTH-1, both 1 at cycle DEPTH; read of addresses 0, 5, DEPTH-1 → rsp_rdata=0, rsp_err=0.
- Write addr 3 = 0xDEADBEEF, be=4'hF; write addr 3 = 0x00001100, be=4'b0010; read addr 3 → 0xDEAD11EF one cycle after accept.
- Write addr 7 = 0x12345678 at edge N, read addr 7 at N+1, read addr 7 and addr 8 back-to-back → 0x12345678, then 0x12345678, 0x00000000 on consecutive rsp_valid cycles.
- Read addr DEPTH (1024) → rsp_valid=1, rsp_err=1, rsp_rdata=0; write addr DEPTH+5 → wr_err=1 one cycle, subsequent read of addr 5 still 0.
- Assert rst at INIT count 500 for one cycle → init_done rises exactly DEPTH cycles after rst deasserts, not earlier.
- Fill addr 0..15 with addr*0x01010101, pulse rst, wait init_done, read 0..15 → all 0; rst on cycle after a read accept → no rsp_valid.

Source files
------------

// File: rtl/m9k_mem_ctrl.sv
// Single-port M9K scratch RAM controller: valid/ready requests, byte-enable writes,
// registered read response, out-of-range detection and a post-reset zero-fill sweep.
module m9k_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  init_done_o,
  output logic                  wr_err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                init_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   ram_q;
  logic                zero_q;
  logic                rsp_valid_q, rsp_err_q, wr_err_q;

  logic                in_range, accept, rd_acc, wr_acc;
  logic [IDX_W-1:0]    idx;

  assign in_range = {1'b0, req_addr_i} < DEPTH_X;
  assign idx      = req_addr_i[IDX_W-1:0];
  assign accept   = req_valid_i & (state_q == S_RUN) & ~rst_i;
  assign rd_acc   = accept & ~req_we_i;
  assign wr_acc   = accept & req_we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = ~rst_i;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Read register doubles as the M9K output register; it is never reset.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be_i[b]) mem_q[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
    if (rd_acc && in_range) ram_q <= mem_q[idx];
  end

  // zero_q forces rdata to 0 after reset and after an out-of-range read, and holds it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rd_acc;
      rsp_err_q   <= rd_acc & ~in_range;
      wr_err_q    <= wr_acc & ~in_range;
      if (rd_acc) zero_q <= ~in_range;
    end
  end

  assign req_ready_o = (state_q == S_RUN);
  assign init_done_o = (state_q == S_RUN);
  assign rsp_valid_o = rsp_valid_q & ~rst_i;
  assign rsp_err_o   = rsp_err_q & ~rst_i;
  assign rsp_rdata_o = zero_q ? '0 : ram_q;
  assign wr_err_o    = wr_err_q;

endmodule
